// File: rtl/regscan_pkg.sv
// Shared definitions for the register-file scan reader: default widths,
// state encoding and the read-latency legality check.
package regscan_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_RD_LAT     = 1;

  // State encoding, also visible on the debug state port.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_EMIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_READ = ST_READ,
    S_WAIT = ST_WAIT,
    S_EMIT = ST_EMIT,
    S_DONE = ST_DONE
  } state_t;

  // The register file either answers combinationally or one cycle later.
  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat == 0) || (lat == 1);
  endfunction

endpackage

// File: rtl/regscan_addr_ctr.sv
// Scan address counter: synchronous clear has priority over increment,
// o_last flags the final register address.
module regscan_addr_ctr
  import regscan_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_cnt,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_cnt;

  // Address register: cleared on scan exit, advanced after each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = &r_cnt;

endmodule

// File: rtl/regfile_scan_reader.sv
// Register-file scan reader: on start, walks every register address, reads
// each entry and streams (addr, data) beats to a downstream consumer.
// Handshake: a beat transfers on a rising edge where out_valid && out_ready;
// once raised, out_valid and the beat payload hold until that transfer, except
// that abort drops a pending beat.
// Optional build macro REGSCAN_X0_ZERO_EN: address 0 is reported as data 0
// (hardwired x0) without using rdata; timing is unchanged.
module regfile_scan_reader
  import regscan_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RD_LAT     = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            dbg_state
);

  // An illegal latency falls back to the safe one-cycle read path.
  localparam bit RD_LAT_OK = rd_lat_legal(RD_LAT);
  localparam bit USE_WAIT  = RD_LAT_OK ? (RD_LAT == 1) : 1'b1;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic [ADDR_WIDTH-1:0] w_cnt;
  logic                  w_last;
  logic                  w_clr;
  logic                  w_inc;
  logic [DATA_WIDTH-1:0] w_cap_data;

  // Counter returns to 0 on every entry to IDLE; it advances only on a
  // non-final accepted beat, so it never wraps inside a scan.
  assign w_clr = (r_state != S_IDLE) && (abort || (r_state == S_DONE));
  assign w_inc = (r_state == S_EMIT) && out_ready && !abort && !w_last;

  regscan_addr_ctr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_cnt (w_cnt),
    .o_last(w_last)
  );

`ifdef REGSCAN_X0_ZERO_EN
  assign w_cap_data = (w_cnt == '0) ? '0 : rdata;
`else
  assign w_cap_data = rdata;
`endif

  // Scan sequencer with registered outputs; abort overrides every non-IDLE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != S_IDLE) && abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
            end
          end
          S_READ: begin
            if (USE_WAIT) begin
              r_state <= S_WAIT;
            end else begin
              r_state    <= S_EMIT;
              r_valid    <= 1'b1;
              r_out_addr <= w_cnt;
              r_out_data <= w_cap_data;
            end
          end
          S_WAIT: begin
            r_state    <= S_EMIT;
            r_valid    <= 1'b1;
            r_out_addr <= w_cnt;
            r_out_data <= w_cap_data;
          end
          S_EMIT: begin
            if (out_ready) begin
              r_valid <= 1'b0;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_READ;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign raddr     = w_cnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Bench for regfile_scan_reader: two instances (RD_LAT=1 and RD_LAT=0,
// ADDR_WIDTH=2) share stimulus; an abstract beat-schedule model is compared
// every cycle, and directed tests pin timing and data with literal values.
module tb_regfile_scan_reader;

  localparam int AW   = 2;
  localparam int DW   = 32;
  localparam int NREG = 4;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic ready;
  logic [DW-1:0] regs [NREG];

  logic          busy1, done1, valid1;
  logic [AW-1:0] raddr1, addr1;
  logic [DW-1:0] rdata1, data1;
  logic [2:0]    dbg1;
  logic          busy0, done0, valid0;
  logic [AW-1:0] raddr0, addr0;
  logic [DW-1:0] rdata0, data0;
  logic [2:0]    dbg0;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int st       = 0;

  typedef struct {
    int            cyc;
    int            addr;
    logic [DW-1:0] data;
  } beat_t;
  beat_t beat1_q[$];
  beat_t beat0_q[$];
  int    done1_q[$];
  int    done0_q[$];
  logic [DW-1:0] exp_q[$];

  // Abstract model: a scan is a list of beats; each beat appears (lat+1)
  // cycles after the scan starts or the previous beat is taken.
  typedef struct {
    bit            active;
    bit            valid;
    bit            done;
    int            idx;
    int            delay;
    logic [DW-1:0] data;
  } model_t;
  model_t m1, m0;

  regfile_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy1), .done(done1), .raddr(raddr1), .rdata(rdata1),
    .out_valid(valid1), .out_ready(ready), .out_addr(addr1), .out_data(data1),
    .dbg_state(dbg1)
  );

  regfile_scan_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy0), .done(done0), .raddr(raddr0), .rdata(rdata0),
    .out_valid(valid0), .out_ready(ready), .out_addr(addr0), .out_data(data0),
    .dbg_state(dbg0)
  );

  // Clock and register-file read ports (registered and combinational).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rdata1 <= regs[raddr1];
  assign rdata0 = regs[raddr0];

  function automatic logic [DW-1:0] reg_value(input int idx);
`ifdef REGSCAN_X0_ZERO_EN
    if (idx == 0) return '0;
`endif
    return regs[idx];
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.active = 1'b0; m.valid = 1'b0; m.done = 1'b0;
    m.idx = 0; m.delay = 0; m.data = '0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input int lat);
    model_t n = m;
    if (!m.active) begin
      if (start && !abort) begin
        n.active = 1'b1; n.idx = 0; n.delay = lat; n.valid = 1'b0;
      end
    end else if (abort || m.done) begin
      n = model_reset();
    end else if (m.valid) begin
      if (ready) begin
        n.valid = 1'b0;
        if (m.idx == NREG - 1) n.done = 1'b1;
        else begin n.idx = m.idx + 1; n.delay = lat; end
      end
    end else if (m.delay == 0) begin
      n.valid = 1'b1;
      n.data  = reg_value(m.idx);
    end else begin
      n.delay = m.delay - 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic chk_model(input string tag, input model_t m, input logic b, input logic d,
                           input logic v, input logic [AW-1:0] ra, input logic [AW-1:0] oa,
                           input logic [DW-1:0] od);
    chk({tag, ".busy"},  32'(b),  32'(m.active));
    chk({tag, ".done"},  32'(d),  32'(m.done));
    chk({tag, ".valid"}, 32'(v),  32'(m.valid));
    chk({tag, ".raddr"}, 32'(ra), m.active ? 32'(m.idx) : 32'd0);
    if (m.valid) begin
      chk({tag, ".out_addr"}, 32'(oa), 32'(m.idx));
      chk({tag, ".out_data"}, od, m.data);
    end
  endtask

  // Model advance and handshake logging, on the active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = model_reset();
      m0 = model_reset();
    end else begin
      if (valid1 && ready) beat1_q.push_back('{cyc, int'(addr1), data1});
      if (valid0 && ready) beat0_q.push_back('{cyc, int'(addr0), data0});
      if (done1) done1_q.push_back(cyc);
      if (done0) done0_q.push_back(cyc);
      m1 = model_step(m1, 1);
      m0 = model_step(m0, 0);
      cyc = cyc + 1;
    end
  end

  // Per-cycle compare against the model, on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst.busy1", 32'(busy1), 0);   chk("rst.valid1", 32'(valid1), 0);
      chk("rst.done1", 32'(done1), 0);   chk("rst.raddr1", 32'(raddr1), 0);
      chk("rst.addr1", 32'(addr1), 0);   chk("rst.data1", data1, 0);
      chk("rst.busy0", 32'(busy0), 0);   chk("rst.valid0", 32'(valid0), 0);
      chk("rst.data0", data0, 0);
    end else begin
      chk_model("lat1", m1, busy1, done1, valid1, raddr1, addr1, data1);
      chk_model("lat0", m0, busy0, done0, valid0, raddr0, addr0, data0);
    end
  end

  task automatic clear_logs();
    beat1_q.delete(); beat0_q.delete(); done1_q.delete(); done0_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    start = 1'b1;
    st = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy1 || busy0) && n < 80);
    chk({name, ".idle_timeout"}, 32'(busy1 || busy0), 0);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 60) begin @(negedge clk); n++; end
    chk("wait_cyc", 32'(cyc), 32'(target));
  endtask

  task automatic wait_beat(input int a, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(valid1 && addr1 == AW'(a)) && n < 40);
    chk({name, ".beat_seen"}, 32'(valid1 && addr1 == AW'(a)), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    for (int i = 0; i < NREG; i++) regs[i] = 32'h11 * (i + 1);
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Test 1: full scan, ready held high; spacing 3 (lat 1) and 2 (lat 0).
    clear_logs();
    pulse_start();
    wait_idle("t1");
    chk("t1.beats1", beat1_q.size(), 4);
    chk("t1.beats0", beat0_q.size(), 4);
    if (beat1_q.size() == 4 && beat0_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t1.addr1[%0d]", i), 32'(beat1_q[i].addr), 32'(i));
        chk($sformatf("t1.data1[%0d]", i), beat1_q[i].data, exp_q[i]);
        chk($sformatf("t1.time1[%0d]", i), 32'(beat1_q[i].cyc - st), 32'(3 + 3 * i));
        chk($sformatf("t1.data0[%0d]", i), beat0_q[i].data, exp_q[i]);
        chk($sformatf("t1.time0[%0d]", i), 32'(beat0_q[i].cyc - st), 32'(2 + 2 * i));
      end
    end
    chk("t1.ndone1", done1_q.size(), 1);
    chk("t1.ndone0", done0_q.size(), 1);
    if (done1_q.size() == 1) chk("t1.done1_time", 32'(done1_q[0] - st), 13);
    if (done0_q.size() == 1) chk("t1.done0_time", 32'(done0_q[0] - st), 9);

    // Test 2: stall beat 1 for 5 cycles; payload must hold.
    clear_logs();
    pulse_start();
    wait_beat(1, "t2");
    #1 ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2.hold_valid", 32'(valid1), 1);
      chk("t2.hold_addr", 32'(addr1), 1);
      chk("t2.hold_data", data1, 32'h22);
    end
    #1 ready = 1'b1;
    wait_idle("t2");
    chk("t2.beats1", beat1_q.size(), 4);
    if (beat1_q.size() == 4) begin
      chk("t2.beat1_time", 32'(beat1_q[1].cyc - st), 11);
      chk("t2.beat3_time", 32'(beat1_q[3].cyc - st), 17);
      chk("t2.beat1_data", beat1_q[1].data, 32'h22);
    end

    // Test 3: abort during WAIT of address 2, then a fresh scan.
    clear_logs();
    pulse_start();
    wait_cyc(st + 8);
    chk("t3.in_wait", 32'(dbg1), 32'(regscan_pkg::ST_WAIT));
    chk("t3.raddr", 32'(raddr1), 2);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("t3.busy1", 32'(busy1), 0);
    chk("t3.valid1", 32'(valid1), 0);
    chk("t3.busy0", 32'(busy0), 0);
    #1 abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3.no_done1", done1_q.size(), 0);
    chk("t3.no_done0", done0_q.size(), 0);
    clear_logs();
    pulse_start();
    wait_idle("t3b");
    chk("t3.rescan_n", beat1_q.size(), 4);
    if (beat1_q.size() > 0) begin
      chk("t3.rescan_addr0", 32'(beat1_q[0].addr), 0);
      chk("t3.rescan_data0", beat1_q[0].data, 32'h11);
    end

    // Test 4: start while busy is ignored; start+abort in IDLE stays IDLE.
    clear_logs();
    pulse_start();
    wait_cyc(st + 4);
    #1 start = 1'b1;
    @(negedge clk);
    chk("t4.busy_kept", 32'(busy1), 1);
    #1 start = 1'b0;
    wait_idle("t4");
    chk("t4.beats1", beat1_q.size(), 4);
    chk("t4.ndone1", done1_q.size(), 1);
    if (done1_q.size() == 1) chk("t4.done1_time", 32'(done1_q[0] - st), 13);
    #1 start = 1'b1; abort = 1'b1;
    @(negedge clk);
    #1 start = 1'b0; abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4.sa_busy1", 32'(busy1), 0);
      chk("t4.sa_busy0", 32'(busy0), 0);
    end

    // Test 5: register 0 holds 0xDEAD.
    #1 regs[0] = 32'hDEAD;
    clear_logs();
    pulse_start();
    wait_idle("t5");
    if (beat1_q.size() > 0 && beat0_q.size() > 0) begin
`ifdef REGSCAN_X0_ZERO_EN
      chk("t5.x0_lat1", beat1_q[0].data, 32'h0);
      chk("t5.x0_lat0", beat0_q[0].data, 32'h0);
`else
      chk("t5.x0_lat1", beat1_q[0].data, 32'hDEAD);
      chk("t5.x0_lat0", beat0_q[0].data, 32'hDEAD);
`endif
    end else begin
      chk("t5.beats_present", 0, 1);
    end

    // Test 6: asynchronous reset while a beat is presented.
    clear_logs();
    pulse_start();
    wait_beat(1, "t6");
    #1 rst_n = 1'b0;
    #1;
    chk("t6.busy1", 32'(busy1), 0);   chk("t6.valid1", 32'(valid1), 0);
    chk("t6.addr1", 32'(addr1), 0);   chk("t6.data1", data1, 0);
    chk("t6.raddr1", 32'(raddr1), 0); chk("t6.done1", 32'(done1), 0);
    chk("t6.busy0", 32'(busy0), 0);   chk("t6.data0", data0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6.no_done1", done1_q.size(), 0);
    chk("t6.idle1", 32'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
